// File: rtl/adder8.sv
// Registered 8-bit two-level carry-lookahead adder for the Tiny Tapeout user slot.
// Define ADDER8_SAT_EN to clamp overflowing sums to 8'hFF instead of wrapping.
module adder8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // 4-bit lookahead group: returns {group_g, group_p, c3, c2, c1, c0}
    function automatic logic [5:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic cin);
        logic [3:0] c;
        logic       gg;
        logic       gp;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp   = p[3] & p[2] & p[1] & p[0];
        return {gg, gp, c};
    endfunction

    logic [7:0] g;
    logic [7:0] p;
    logic [5:0] grp0;
    logic [5:0] grp1;
    logic       c4;
    logic       c8;
    logic [7:0] carry;
    logic [7:0] sum;
    logic [7:0] sum_next;
    logic [7:0] sum_q;
    logic       cout_q;

    // Bit generate/propagate, second-level group carries and sum bits
    always_comb begin
        g     = ui_in & uio_in;
        p     = ui_in ^ uio_in;
        grp0  = cla4(g[3:0], p[3:0], 1'b0);
        // Carry into bit 4 from group 0 lookahead terms (carry-in is zero)
        c4    = grp0[5] | (grp0[4] & 1'b0);
        grp1  = cla4(g[7:4], p[7:4], c4);
        c8    = grp1[5] | (grp1[4] & grp0[5]);
        carry = {grp1[3:0], grp0[3:0]};
        sum   = p ^ carry;
    end

    // Select the value captured into the sum register
    always_comb begin
        sum_next = sum;
`ifdef ADDER8_SAT_EN
        if (c8 == 1'b1) begin
            sum_next = 8'hFF;
        end else begin
            sum_next = sum;
        end
`endif
    end

    // Result registers with asynchronous active-high reset and clock enable
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sum_q  <= 8'h00;
            cout_q <= 1'b0;
        end else if (ena) begin
            sum_q  <= sum_next;
            cout_q <= c8;
        end else begin
            sum_q  <= sum_q;
            cout_q <= cout_q;
        end
    end

    assign uo_out  = sum_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_adder8.sv
// Scoreboard bench for adder8: stimulus queues expected results, a monitor
// compares them on the falling edge after the capturing rising edge.
module tb_adder8;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] s;
        logic       c;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    adder8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive operands at a falling edge; expect the result after the next rising edge
    task automatic issue(input int id, input logic en, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic c);
        exp_t e;
        @(negedge clk);
        ena    = en;
        ui_in  = a;
        uio_in = b;
        e.cyc  = cyc + 1;
        e.id   = id;
        e.s    = s;
        e.c    = c;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expectation due at this cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check8($sformatf("sum#%0d", e.id), uo_out, e.s);
                check8($sformatf("cout#%0d", e.id), {7'd0, dut.cout_q}, {7'd0, e.c});
                check8($sformatf("uio_out#%0d", e.id), uio_out, 8'h00);
            end
        end
    end

`ifdef ADDER8_SAT_EN
    localparam logic [7:0] OVF_255_1   = 8'hFF;
    localparam logic [7:0] OVF_200_100 = 8'hFF;
`else
    localparam logic [7:0] OVF_255_1   = 8'h00;
    localparam logic [7:0] OVF_200_100 = 8'd44;
`endif

    initial begin
        int wait_cnt;
        rst_n  = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h0C;
        uio_in = 8'h07;
        #2;
        check8("reset_uo_out", uo_out, 8'h00);
        check8("reset_uio_out", uio_out, 8'h00);
        check8("reset_uio_oe", uio_oe, 8'h00);
        check8("reset_cout", {7'd0, dut.cout_q}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;

        issue(1, 1'b1, 8'd12,  8'd7,   8'h13, 1'b0);
        issue(2, 1'b1, 8'd240, 8'd15,  8'hFF, 1'b0);
        issue(3, 1'b1, 8'd170, 8'd85,  8'hFF, 1'b0);
        issue(4, 1'b1, 8'h0F,  8'h01,  8'h10, 1'b0);
        issue(5, 1'b1, 8'd255, 8'd1,   OVF_255_1, 1'b1);
        issue(6, 1'b1, 8'd12,  8'd7,   8'h13, 1'b0);
        issue(7, 1'b0, 8'd200, 8'd100, 8'h13, 1'b0);
        issue(8, 1'b0, 8'd200, 8'd100, 8'h13, 1'b0);
        issue(9, 1'b0, 8'd200, 8'd100, 8'h13, 1'b0);
        issue(10, 1'b1, 8'd200, 8'd100, OVF_200_100, 1'b1);
        issue(11, 1'b1, 8'd128, 8'd127, 8'hFF, 1'b0);
        issue(12, 1'b1, 8'd12,  8'd7,   8'h13, 1'b0);

        // Asynchronous reset pulse between edges, once result 12 is visible
        @(negedge clk);
        ena = 1'b0;
        #1;
        check8("pre_reset_uo_out", uo_out, 8'h13);
        rst_n = 1'b1;
        #1;
        check8("async_reset_uo_out", uo_out, 8'h00);
        check8("async_reset_cout", {7'd0, dut.cout_q}, 8'h00);
        rst_n = 1'b0;

        issue(13, 1'b1, 8'd1,  8'd2,  8'h03, 1'b0);
        issue(14, 1'b1, 8'd99, 8'd99, 8'd198, 1'b0);

        // Operand change with no clock edge must not disturb the output
        @(negedge clk);
        ena    = 1'b1;
        ui_in  = 8'hAA;
        uio_in = 8'h11;
        #2;
        check8("no_comb_path", uo_out, 8'd198);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
